// File: rtl/writeback_stage.sv
`default_nettype none
// ============================================================================
// Module   : writeback_stage
// Purpose  : Decision/writeback stage. Turns the instruction forwarded from
//            the memory-access stage into register-file writes (full data or
//            16-bit immediate), ALU commit/status strobes and jump requests.
//            Loads may stall in LOAD_WAIT until mem_valid arrives, with a
//            bus_error pulse if it does not arrive in LOAD_TIMEOUT cycles.
// Ports    : clock/reset           - clock, synchronous active-high reset
//            in_valid/in_ready     - input handshake (in_ready=0 in LOAD_WAIT)
//            in_instruction        - 32-bit instruction
//            return_address        - link value for BRANCH/JUMP
//            mem_data/mem_valid    - load data return
//            alu_carry/zero/neg/over - status flags for condition evaluation
//            out_instruction/out_valid - accepted instruction, 1-cycle valid
//            write/write_index/write_data - register write
//            write_immediate[_data/_type] - immediate register write
//            alu_cycle, status_register_write, jump, bus_error - strobes
//            fwd_valid/fwd_index/fwd_data - same-cycle bypass of the write
// Config   : WRITEBACK_FORWARD_EN - when defined, fwd_* mirror the registered
//            write; otherwise fwd_* are tied to zero.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module writeback_stage #(
  parameter int DATA_WIDTH    = 32,
  parameter int REG_IDX_WIDTH = 4,
  parameter int LOAD_TIMEOUT  = 15
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_instruction,
  input  logic [DATA_WIDTH-1:0]    return_address,
  input  logic [DATA_WIDTH-1:0]    mem_data,
  input  logic                     mem_valid,
  input  logic                     alu_carry,
  input  logic                     alu_zero,
  input  logic                     alu_neg,
  input  logic                     alu_over,
  output logic [31:0]              out_instruction,
  output logic                     out_valid,
  output logic                     write,
  output logic [REG_IDX_WIDTH-1:0] write_index,
  output logic [DATA_WIDTH-1:0]    write_data,
  output logic                     write_immediate,
  output logic [15:0]              write_immediate_data,
  output logic [1:0]               write_immediate_type,
  output logic                     alu_cycle,
  output logic                     status_register_write,
  output logic                     jump,
  output logic                     bus_error,
  output logic                     fwd_valid,
  output logic [REG_IDX_WIDTH-1:0] fwd_index,
  output logic [DATA_WIDTH-1:0]    fwd_data
);

  // Opcodes live in instr[31:27].
  localparam logic [4:0] OPCODE_NOP    = 5'h00;
  localparam logic [4:0] OPCODE_ALU    = 5'h01;
  localparam logic [4:0] OPCODE_ALUM   = 5'h02;
  localparam logic [4:0] OPCODE_ALUMI  = 5'h03;
  localparam logic [4:0] OPCODE_LOADI  = 5'h04;
  localparam logic [4:0] OPCODE_LOAD   = 5'h05;
  localparam logic [4:0] OPCODE_LOADR  = 5'h06;
  localparam logic [4:0] OPCODE_BRANCH = 5'h07;
  localparam logic [4:0] OPCODE_JUMP   = 5'h08;

  // Condition codes in instr[15:12]; code 15 is undefined and never true.
  localparam logic [3:0] COND_AL = 4'd0;
  localparam logic [3:0] COND_EQ = 4'd1;
  localparam logic [3:0] COND_NE = 4'd2;
  localparam logic [3:0] COND_CS = 4'd3;
  localparam logic [3:0] COND_CC = 4'd4;
  localparam logic [3:0] COND_MI = 4'd5;
  localparam logic [3:0] COND_PL = 4'd6;
  localparam logic [3:0] COND_VS = 4'd7;
  localparam logic [3:0] COND_VC = 4'd8;
  localparam logic [3:0] COND_HI = 4'd9;
  localparam logic [3:0] COND_LS = 4'd10;
  localparam logic [3:0] COND_GE = 4'd11;
  localparam logic [3:0] COND_LT = 4'd12;
  localparam logic [3:0] COND_GT = 4'd13;
  localparam logic [3:0] COND_LE = 4'd14;

  localparam logic [1:0] IT_UNSIGNED = 2'd0;
  localparam logic [1:0] CW_BYTE     = 2'd0;
  localparam logic [1:0] CW_WORD     = 2'd1;

  localparam logic [7:0] TIMEOUT_LAST = 8'(LOAD_TIMEOUT - 1);

  typedef enum logic [0:0] {
    ST_RUN       = 1'b0,
    ST_LOAD_WAIT = 1'b1
  } state_t;

  function automatic logic cond_true(input logic [3:0] c, input logic cf,
                                     input logic zf, input logic nf, input logic vf);
    logic r;
    case (c)
      COND_AL: r = 1'b1;
      COND_EQ: r = zf;
      COND_NE: r = !zf;
      COND_CS: r = cf;
      COND_CC: r = !cf;
      COND_MI: r = nf;
      COND_PL: r = !nf;
      COND_VS: r = vf;
      COND_VC: r = !vf;
      COND_HI: r = cf && !zf;
      COND_LS: r = !cf || zf;
      COND_GE: r = (nf == vf);
      COND_LT: r = (nf != vf);
      COND_GT: r = !zf && (nf == vf);
      COND_LE: r = zf || (nf != vf);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // instr[26:25] selects byte/halfword/full, instr[24] selects sign extension.
  function automatic logic [DATA_WIDTH-1:0] extend_load(input logic [DATA_WIDTH-1:0] d,
                                                        input logic [31:0] instr);
    logic [DATA_WIDTH-1:0] r;
    case (instr[26:25])
      CW_BYTE: r = instr[24] ? DATA_WIDTH'($signed(d[7:0]))  : DATA_WIDTH'(d[7:0]);
      CW_WORD: r = instr[24] ? DATA_WIDTH'($signed(d[15:0])) : DATA_WIDTH'(d[15:0]);
      default: r = d;
    endcase
    return r;
  endfunction

  state_t                   state_q, state_d;
  logic [7:0]               count_q, count_d;
  logic [31:0]              out_instruction_q, out_instruction_d;
  logic                     out_valid_q, out_valid_d;
  logic                     write_q, write_d;
  logic [REG_IDX_WIDTH-1:0] write_index_q, write_index_d;
  logic [DATA_WIDTH-1:0]    write_data_q, write_data_d;
  logic                     write_immediate_q, write_immediate_d;
  logic [15:0]              imm_data_q, imm_data_d;
  logic [1:0]               imm_type_q, imm_type_d;
  logic                     alu_cycle_q, alu_cycle_d;
  logic                     status_write_q, status_write_d;
  logic                     jump_q, jump_d;
  logic                     bus_error_q, bus_error_d;
  logic                     accept;
  logic [4:0]               opcode;

  assign accept = in_valid && (state_q == ST_RUN);
  assign opcode = in_instruction[31:27];

  always_comb begin
    state_d           = state_q;
    count_d           = count_q;
    out_instruction_d = out_instruction_q;
    write_index_d     = write_index_q;
    write_data_d      = write_data_q;
    imm_data_d        = imm_data_q;
    imm_type_d        = imm_type_q;
    out_valid_d       = 1'b0;
    write_d           = 1'b0;
    write_immediate_d = 1'b0;
    alu_cycle_d       = 1'b0;
    status_write_d    = 1'b0;
    jump_d            = 1'b0;
    bus_error_d       = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (accept) begin
          out_instruction_d = in_instruction;
          case (opcode)
            OPCODE_LOADI: begin
              write_immediate_d = 1'b1;
              write_index_d     = in_instruction[20 +: REG_IDX_WIDTH];
              imm_data_d        = in_instruction[15:0];
              imm_type_d        = in_instruction[26:25];
              out_valid_d       = 1'b1;
            end
            // The ALU result itself reaches the register file via alu_cycle;
            // write_data carries no payload for these opcodes.
            OPCODE_ALU, OPCODE_ALUM, OPCODE_ALUMI: begin
              alu_cycle_d    = 1'b1;
              status_write_d = 1'b1;
              write_d        = 1'b1;
              write_index_d  = in_instruction[20 +: REG_IDX_WIDTH];
              write_data_d   = '0;
              out_valid_d    = 1'b1;
            end
            OPCODE_BRANCH, OPCODE_JUMP: begin
              out_valid_d = 1'b1;
              if (cond_true(in_instruction[15:12], alu_carry, alu_zero, alu_neg, alu_over)) begin
                jump_d = 1'b1;
                if (in_instruction[24]) begin
                  write_d       = 1'b1;
                  write_index_d = in_instruction[20 +: REG_IDX_WIDTH];
                  write_data_d  = return_address;
                end
              end
            end
            OPCODE_LOAD, OPCODE_LOADR: begin
              if (mem_valid) begin
                write_d       = 1'b1;
                write_index_d = in_instruction[20 +: REG_IDX_WIDTH];
                write_data_d  = extend_load(mem_data, in_instruction);
                out_valid_d   = 1'b1;
              end else begin
                state_d = ST_LOAD_WAIT;
                count_d = 8'd0;
              end
            end
            default: out_valid_d = 1'b1;
          endcase
        end
      end
      // out_instruction_q holds the pending load while waiting.
      ST_LOAD_WAIT: begin
        if (mem_valid) begin
          write_d       = 1'b1;
          write_index_d = out_instruction_q[20 +: REG_IDX_WIDTH];
          write_data_d  = extend_load(mem_data, out_instruction_q);
          out_valid_d   = 1'b1;
          state_d       = ST_RUN;
          count_d       = 8'd0;
        end else if (count_q == TIMEOUT_LAST) begin
          bus_error_d = 1'b1;
          out_valid_d = 1'b1;
          state_d     = ST_RUN;
          count_d     = 8'd0;
        end else begin
          count_d = count_q + 8'd1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q           <= ST_RUN;
      count_q           <= 8'd0;
      out_instruction_q <= {OPCODE_NOP, 27'h0};
      out_valid_q       <= 1'b0;
      write_q           <= 1'b0;
      write_index_q     <= '0;
      write_data_q      <= '0;
      write_immediate_q <= 1'b0;
      imm_data_q        <= 16'h0;
      imm_type_q        <= IT_UNSIGNED;
      alu_cycle_q       <= 1'b0;
      status_write_q    <= 1'b0;
      jump_q            <= 1'b0;
      bus_error_q       <= 1'b0;
    end else begin
      state_q           <= state_d;
      count_q           <= count_d;
      out_instruction_q <= out_instruction_d;
      out_valid_q       <= out_valid_d;
      write_q           <= write_d;
      write_index_q     <= write_index_d;
      write_data_q      <= write_data_d;
      write_immediate_q <= write_immediate_d;
      imm_data_q        <= imm_data_d;
      imm_type_q        <= imm_type_d;
      alu_cycle_q       <= alu_cycle_d;
      status_write_q    <= status_write_d;
      jump_q            <= jump_d;
      bus_error_q       <= bus_error_d;
    end
  end

  assign in_ready              = (state_q == ST_RUN);
  assign out_instruction       = out_instruction_q;
  assign out_valid             = out_valid_q;
  assign write                 = write_q;
  assign write_index           = write_index_q;
  assign write_data            = write_data_q;
  assign write_immediate       = write_immediate_q;
  assign write_immediate_data  = imm_data_q;
  assign write_immediate_type  = imm_type_q;
  assign alu_cycle             = alu_cycle_q;
  assign status_register_write = status_write_q;
  assign jump                  = jump_q;
  assign bus_error             = bus_error_q;

`ifdef WRITEBACK_FORWARD_EN
  // Immediates forward zero-extended only for IT_UNSIGNED; other types sign-extend.
  assign fwd_valid = write_q || write_immediate_q;
  assign fwd_index = write_index_q;
  assign fwd_data  = write_immediate_q
                   ? ((imm_type_q == IT_UNSIGNED) ? DATA_WIDTH'(imm_data_q)
                                                  : DATA_WIDTH'($signed(imm_data_q)))
                   : write_data_q;
`else
  assign fwd_valid = 1'b0;
  assign fwd_index = '0;
  assign fwd_data  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_writeback_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_writeback_stage
// Purpose  : Self-checking bench for writeback_stage: directed scenarios then
//            randomized traffic, compared every cycle against a behavioural
//            reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_writeback_stage;
  localparam int DW = 32;
  localparam int IW = 4;
  localparam int LT = 15;

  localparam logic [4:0] OP_NOP = 5'h00, OP_ALU = 5'h01, OP_ALUM = 5'h02, OP_ALUMI = 5'h03;
  localparam logic [4:0] OP_LOADI = 5'h04, OP_LOAD = 5'h05, OP_LOADR = 5'h06;
  localparam logic [4:0] OP_BRANCH = 5'h07, OP_JUMP = 5'h08;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [31:0]   in_instruction = '0;
  logic [DW-1:0] return_address = '0;
  logic [DW-1:0] mem_data = '0;
  logic          mem_valid = 1'b0;
  logic          alu_carry = 1'b0, alu_zero = 1'b0, alu_neg = 1'b0, alu_over = 1'b0;
  logic [31:0]   out_instruction;
  logic          out_valid, write, write_immediate, alu_cycle, status_register_write;
  logic          jump, bus_error, fwd_valid;
  logic [IW-1:0] write_index, fwd_index;
  logic [DW-1:0] write_data, fwd_data;
  logic [15:0]   write_immediate_data;
  logic [1:0]    write_immediate_type;

  writeback_stage #(.DATA_WIDTH(DW), .REG_IDX_WIDTH(IW), .LOAD_TIMEOUT(LT)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_instruction(in_instruction), .return_address(return_address),
    .mem_data(mem_data), .mem_valid(mem_valid),
    .alu_carry(alu_carry), .alu_zero(alu_zero), .alu_neg(alu_neg), .alu_over(alu_over),
    .out_instruction(out_instruction), .out_valid(out_valid),
    .write(write), .write_index(write_index), .write_data(write_data),
    .write_immediate(write_immediate), .write_immediate_data(write_immediate_data),
    .write_immediate_type(write_immediate_type), .alu_cycle(alu_cycle),
    .status_register_write(status_register_write), .jump(jump), .bus_error(bus_error),
    .fwd_valid(fwd_valid), .fwd_index(fwd_index), .fwd_data(fwd_data)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model state: a pending load and how many cycles it has waited.
  bit          m_busy = 1'b0;
  int          m_waited = 0;
  logic [31:0] m_pend = '0;

  // Expected outputs for the cycle after the current edge.
  bit          e_write, e_wi, e_alu, e_srw, e_jump, e_ov, e_be, e_ready, e_rst;
  logic [31:0] e_instr = '0;
  logic [IW-1:0] e_idx = '0;
  logic [DW-1:0] e_data = '0;
  logic [15:0] e_imm = '0;
  logic [1:0]  e_type = '0;

  function automatic bit cond_holds(input int c, input bit cf, input bit zf, input bit nf, input bit vf);
    case (c)
      0: return 1;
      1: return zf;
      2: return !zf;
      3: return cf;
      4: return !cf;
      5: return nf;
      6: return !nf;
      7: return vf;
      8: return !vf;
      9: return cf && !zf;
      10: return !cf || zf;
      11: return nf == vf;
      12: return nf != vf;
      13: return !zf && (nf == vf);
      14: return zf || (nf != vf);
      default: return 0;
    endcase
  endfunction

  // Take the low w bits of the data, then reinterpret as two's complement if signed.
  function automatic logic [31:0] load_value(input logic [31:0] ins, input logic [31:0] d);
    longint unsigned m, v;
    int w;
    w = (ins[26:25] == 2'd0) ? 8 : (ins[26:25] == 2'd1) ? 16 : 32;
    m = 64'd1 << w;
    v = {32'h0, d} % m;
    if (ins[24] && v >= m / 2) v = v - m;
    return v[31:0];
  endfunction

  function automatic logic [31:0] imm_value(input logic [15:0] imm, input logic [1:0] t);
    longint unsigned v;
    v = {48'h0, imm};
    if (t != 2'd0 && v >= 64'd32768) v = v - 64'd65536;
    return v[31:0];
  endfunction

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [1:0] t, input logic s,
                                     input logic [3:0] idx, input logic [15:0] imm);
    return {op, t, s, idx, 4'h0, imm};
  endfunction

  task automatic model_step();
    logic [4:0] op;
    {e_write, e_wi, e_alu, e_srw, e_jump, e_ov, e_be, e_rst} = '0;
    op = in_instruction[31:27];
    if (reset) begin
      m_busy = 0; e_rst = 1;
      e_instr = {OP_NOP, 27'h0}; e_idx = '0; e_data = '0; e_imm = '0; e_type = 2'd0;
    end else if (m_busy) begin
      if (mem_valid) begin
        e_write = 1; e_idx = m_pend[23:20]; e_data = load_value(m_pend, mem_data);
        e_ov = 1; m_busy = 0;
      end else begin
        m_waited++;
        if (m_waited == LT) begin e_be = 1; e_ov = 1; m_busy = 0; end
      end
    end else if (in_valid) begin
      e_instr = in_instruction;
      if (op == OP_LOADI) begin
        e_wi = 1; e_idx = in_instruction[23:20]; e_imm = in_instruction[15:0];
        e_type = in_instruction[26:25]; e_ov = 1;
      end else if (op == OP_ALU || op == OP_ALUM || op == OP_ALUMI) begin
        e_alu = 1; e_srw = 1; e_write = 1; e_idx = in_instruction[23:20]; e_data = '0; e_ov = 1;
      end else if (op == OP_BRANCH || op == OP_JUMP) begin
        e_ov = 1;
        if (cond_holds(int'(in_instruction[15:12]), alu_carry, alu_zero, alu_neg, alu_over)) begin
          e_jump = 1;
          if (in_instruction[24]) begin
            e_write = 1; e_idx = in_instruction[23:20]; e_data = return_address;
          end
        end
      end else if (op == OP_LOAD || op == OP_LOADR) begin
        if (mem_valid) begin
          e_write = 1; e_idx = in_instruction[23:20];
          e_data = load_value(in_instruction, mem_data); e_ov = 1;
        end else begin
          m_busy = 1; m_waited = 0; m_pend = in_instruction;
        end
      end else begin
        e_ov = 1;
      end
    end
    e_ready = !m_busy;
  endtask

  task automatic compare();
    check("write", 64'(write), 64'(e_write));
    check("write_immediate", 64'(write_immediate), 64'(e_wi));
    check("alu_cycle", 64'(alu_cycle), 64'(e_alu));
    check("status_register_write", 64'(status_register_write), 64'(e_srw));
    check("jump", 64'(jump), 64'(e_jump));
    check("bus_error", 64'(bus_error), 64'(e_be));
    check("out_valid", 64'(out_valid), 64'(e_ov));
    check("in_ready", 64'(in_ready), 64'(e_ready));
    check("out_instruction", 64'(out_instruction), 64'(e_instr));
    if (e_write || e_wi || e_rst) check("write_index", 64'(write_index), 64'(e_idx));
    if (e_write || e_rst) check("write_data", 64'(write_data), 64'(e_data));
    if (e_wi || e_rst) begin
      check("imm_data", 64'(write_immediate_data), 64'(e_imm));
      check("imm_type", 64'(write_immediate_type), 64'(e_type));
    end
`ifdef WRITEBACK_FORWARD_EN
    check("fwd_valid", 64'(fwd_valid), 64'(e_write || e_wi));
    if (e_write || e_wi) begin
      check("fwd_index", 64'(fwd_index), 64'(e_idx));
      check("fwd_data", 64'(fwd_data), 64'(e_wi ? imm_value(e_imm, e_type) : e_data));
    end
`else
    check("fwd_valid", 64'(fwd_valid), 64'd0);
    check("fwd_index", 64'(fwd_index), 64'd0);
    check("fwd_data", 64'(fwd_data), 64'd0);
`endif
  endtask

  task automatic cycle();
    @(posedge clock);
    model_step();
    #1;
    compare();
  endtask

  task automatic idle();
    in_valid = 0; mem_valid = 0;
  endtask

  initial begin
    // Reset state
    reset = 1; cycle(); cycle();
    reset = 0; cycle();

    // LOADI r3 unsigned BEEF
    in_valid = 1; in_instruction = mk(OP_LOADI, 2'd0, 1'b0, 4'd3, 16'hBEEF);
    cycle(); idle(); cycle();

    // LOAD signed byte r5, data arrives on third wait edge
    in_valid = 1; mem_valid = 0; in_instruction = mk(OP_LOAD, 2'd0, 1'b1, 4'd5, 16'h0);
    cycle(); idle(); cycle(); cycle();
    mem_valid = 1; mem_data = 32'h0000_0080; cycle();
    idle(); cycle();

    // LOAD halfword, memory never answers -> timeout
    in_valid = 1; in_instruction = mk(OP_LOAD, 2'd1, 1'b0, 4'd7, 16'h0);
    cycle(); idle();
    for (int i = 0; i < LT + 2; i++) cycle();

    // BRANCH EQ with link r14, taken then not taken
    in_valid = 1; in_instruction = mk(OP_BRANCH, 2'd0, 1'b1, 4'd14, 16'h1000);
    alu_zero = 1; return_address = 32'h100; cycle();
    alu_zero = 0; cycle();
    idle(); cycle();

    // ALU r2 then LOADI r1 back to back
    in_valid = 1; in_instruction = mk(OP_ALU, 2'd0, 1'b0, 4'd2, 16'h0); cycle();
    in_instruction = mk(OP_LOADI, 2'd2, 1'b0, 4'd1, 16'h8001); cycle();
    idle(); cycle();

    // Reset while waiting on a load
    in_valid = 1; in_instruction = mk(OP_LOADR, 2'd2, 1'b0, 4'd9, 16'h0);
    cycle(); idle(); cycle(); cycle();
    reset = 1; cycle();
    reset = 0; cycle();

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      int r;
      logic [4:0] op;
      r = $urandom_range(0, 9);
      op = (r < 9) ? 5'(r) : 5'($urandom);
      in_valid = ($urandom_range(0, 9) < 7);
      in_instruction = {op, 27'($urandom)};
      mem_valid = ($urandom_range(0, 9) < 2);
      mem_data = $urandom;
      return_address = $urandom;
      {alu_carry, alu_zero, alu_neg, alu_over} = 4'($urandom);
      reset = ($urandom_range(0, 199) == 0);
      cycle();
    end
    reset = 0; idle();
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
